// File: rtl/irq_pl_pkg.sv
// rtl/irq_pl_pkg.sv - shared types, constants and sizing helper for the PL interrupt conditioner
package irq_pl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } irq_state_t;

    localparam logic MODE_EDGE  = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

    // Counter width large enough to hold max(pulse, gap) - 1, never narrower than 1 bit
    function automatic int cnt_width(input int pulse_cycles, input int gap_cycles);
        int m;
        m = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/irq_pl_chan.sv
// rtl/irq_pl_chan.sv - single interrupt channel: pulse/gap FSM with pending and coalesced tracking
module irq_pl_chan
    import irq_pl_pkg::*;
#(
    parameter int PULSE_CYCLES = 64,
    parameter int GAP_CYCLES   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic irq_mask,
    input  logic irq_mode,
    input  logic pend_clr,
    output logic irq_out,
    output logic irq_out_nxt,
    output logic irq_pending,
    output logic irq_coalesced
);

    localparam int CW = cnt_width(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

    irq_state_t    state;
    irq_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          irq_d;
    logic          ev;
    logic          pend_req;
    logic          pend_nxt;
    logic          coal_nxt;

    // Request qualification: masked requests never count; edge mode needs a 0->1 transition
    always_comb begin
        ev = ~irq_mask & ((irq_mode == MODE_LEVEL) ? irq_in : (irq_in & ~irq_d));
    end

    // Next-state logic; pending includes a same-cycle request so a re-fire at gap end is not missed
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        irq_out_nxt = irq_out;
        pend_req    = (irq_pending & ~pend_clr) | (ev & (state != IDLE));
        pend_nxt    = pend_req;
        coal_nxt    = (irq_coalesced | (ev & irq_pending)) & ~pend_clr;
        case (state)
            IDLE: begin
                if (ev) begin
                    state_nxt   = ACTIVE;
                    cnt_nxt     = PULSE_LOAD;
                    irq_out_nxt = 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt == '0) begin
                    state_nxt   = GAP;
                    cnt_nxt     = GAP_LOAD;
                    irq_out_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (pend_req) begin
                        // Re-fire ignores the current mask: the request was accepted earlier
                        state_nxt   = ACTIVE;
                        cnt_nxt     = PULSE_LOAD;
                        irq_out_nxt = 1'b1;
                        pend_nxt    = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                irq_out_nxt = 1'b0;
            end
        endcase
    end

    // State registers; edge history tracks irq_in every cycle regardless of mask or state
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            irq_out       <= 1'b0;
            irq_pending   <= 1'b0;
            irq_coalesced <= 1'b0;
            irq_d         <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            irq_out       <= irq_out_nxt;
            irq_pending   <= pend_nxt;
            irq_coalesced <= coal_nxt;
            irq_d         <= irq_in;
        end
    end

endmodule

// File: rtl/irq_pl_multi.sv
// rtl/irq_pl_multi.sv - multi-channel PL interrupt conditioner with aggregate irq line
module irq_pl_multi
    import irq_pl_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int PULSE_CYCLES = 64,
    parameter int GAP_CYCLES   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic [NUM_CH-1:0] irq_mask,
    input  logic [NUM_CH-1:0] irq_mode,
    input  logic [NUM_CH-1:0] pend_clr,
    output logic [NUM_CH-1:0] irq_out,
    output logic              irq_any,
    output logic [NUM_CH-1:0] irq_pending,
    output logic [NUM_CH-1:0] irq_coalesced
);

    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("irq_pl_multi: NUM_CH must be in 1..32");
    end
    if (PULSE_CYCLES < 1) begin : g_bad_pulse
        $error("irq_pl_multi: PULSE_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("irq_pl_multi: GAP_CYCLES must be >= 1");
    end

    logic [NUM_CH-1:0] out_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        irq_pl_chan #(
            .PULSE_CYCLES(PULSE_CYCLES),
            .GAP_CYCLES  (GAP_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .irq_in       (irq_in[i]),
            .irq_mask     (irq_mask[i]),
            .irq_mode     (irq_mode[i]),
            .pend_clr     (pend_clr[i]),
            .irq_out      (irq_out[i]),
            .irq_out_nxt  (out_nxt[i]),
            .irq_pending  (irq_pending[i]),
            .irq_coalesced(irq_coalesced[i])
        );
    end

    // Aggregate line is built from next-state outputs so it lands on the same edge as irq_out
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_any <= 1'b0;
        end else begin
            irq_any <= |out_nxt;
        end
    end

endmodule

// File: tb/tb_irq_pl_multi.sv
// tb/tb_irq_pl_multi.sv - scoreboard bench for irq_pl_multi (64/8 instance and 1/1 boundary instance)
module tb_irq_pl_multi;

    localparam int N   = 4;
    localparam int P_A = 64;
    localparam int G_A = 8;
    localparam int P_B = 1;
    localparam int G_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, rst_b;
    logic [N-1:0] in_a, mask_a, mode_a, clr_a;
    logic [N-1:0] in_b, mask_b, mode_b, clr_b;
    logic [N-1:0] out_a, pend_a, coal_a, out_b, pend_b, coal_b;
    logic         any_a, any_b;
    logic [12:0]  obs_a, obs_b;

    assign obs_a = {out_a, any_a, pend_a, coal_a};
    assign obs_b = {out_b, any_b, pend_b, coal_b};

    irq_pl_multi #(.NUM_CH(N), .PULSE_CYCLES(P_A), .GAP_CYCLES(G_A)) dut_a (
        .clk(clk), .rst(rst_a), .irq_in(in_a), .irq_mask(mask_a), .irq_mode(mode_a),
        .pend_clr(clr_a), .irq_out(out_a), .irq_any(any_a), .irq_pending(pend_a),
        .irq_coalesced(coal_a)
    );

    irq_pl_multi #(.NUM_CH(N), .PULSE_CYCLES(P_B), .GAP_CYCLES(G_B)) dut_b (
        .clk(clk), .rst(rst_b), .irq_in(in_b), .irq_mask(mask_b), .irq_mode(mode_b),
        .pend_clr(clr_b), .irq_out(out_b), .irq_any(any_b), .irq_pending(pend_b),
        .irq_coalesced(coal_b)
    );

    typedef struct packed {
        logic [12:0] a;
        logic [12:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: t = cycles since pulse start (-1 idle); high while t < P, busy until P+G-1
    int           t_m [2][N];
    logic [N-1:0] d_m [2];
    logic [N-1:0] p_m [2];
    logic [N-1:0] c_m [2];

    task automatic model_step(input int k, input int pl, input int gp, input logic r,
                              input logic [N-1:0] din, input logic [N-1:0] dmask,
                              input logic [N-1:0] dmode, input logic [N-1:0] dclr,
                              output logic [12:0] v);
        logic [N-1:0] o;
        logic ev, np;
        for (int c = 0; c < N; c++) begin
            if (r) begin
                t_m[k][c] = -1;
                p_m[k][c] = 1'b0;
                c_m[k][c] = 1'b0;
                d_m[k][c] = 1'b0;
            end else begin
                ev = !dmask[c] && (dmode[c] ? din[c] : (din[c] && !d_m[k][c]));
                if (ev && p_m[k][c]) c_m[k][c] = 1'b1;
                if (dclr[c]) c_m[k][c] = 1'b0;
                np = p_m[k][c] && !dclr[c];
                if (ev && t_m[k][c] != -1) np = 1'b1;
                if (t_m[k][c] == -1) begin
                    if (ev) t_m[k][c] = 0;
                end else if (t_m[k][c] == pl + gp - 1) begin
                    if (np) begin
                        t_m[k][c] = 0;
                        np = 1'b0;
                    end else begin
                        t_m[k][c] = -1;
                    end
                end else begin
                    t_m[k][c] = t_m[k][c] + 1;
                end
                p_m[k][c] = np;
                d_m[k][c] = din[c];
            end
            o[c] = (t_m[k][c] >= 0) && (t_m[k][c] < pl);
        end
        v = {o, |o, p_m[k], c_m[k]};
    endtask

    // One clock: model both instances on the edge, queue the expectation, settle before sampling
    task automatic tick();
        logic [12:0] va, vb;
        exp_t x;
        @(posedge clk);
        model_step(0, P_A, G_A, rst_a, in_a, mask_a, mode_a, clr_a, va);
        model_step(1, P_B, G_B, rst_b, in_b, mask_b, mode_b, clr_b, vb);
        x.a = va;
        x.b = vb;
        sb.push_back(x);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        in_a = '1; mask_a = '0; mode_a = '0; clr_a = '0;
        in_b = '0; mask_b = '0; mode_b = '0; clr_b = '0;
        for (int r = 0; r < 3; r++) begin
            tick();
            e = sb.pop_front(); vectors++;
            if ({obs_a, obs_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("FAIL reset_sb r=%0d got a=%h b=%h want a=%h b=%h", r, obs_a, obs_b, e.a, e.b);
            end
        end
        vectors++;
        if (obs_a !== 13'h0 || obs_b !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_zero got a=%h b=%h want 0 0", obs_a, obs_b);
        end
        in_a = '0;
        rst_a = 1'b0; rst_b = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            e = sb.pop_front(); vectors++;
            if ({obs_a, obs_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("FAIL reset_idle r=%0d got a=%h b=%h want a=%h b=%h", r, obs_a, obs_b, e.a, e.b);
            end
        end
    endtask

    task automatic test_single_pulse();
        int first = -1, last = -1, hi = 0, any_bad = 0;
        for (int r = 0; r < 220; r++) begin
            in_a[0] = (r >= 10 && r < 210);
            tick();
            e = sb.pop_front(); vectors++;
            if ({obs_a, obs_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("FAIL single_sb r=%0d got a=%h b=%h want a=%h b=%h", r, obs_a, obs_b, e.a, e.b);
            end
            if (out_a[0]) begin
                if (first < 0) first = r + 1;
                last = r + 1;
                hi++;
            end
            if (any_a !== out_a[0] || out_a[3:1] !== 3'b000) any_bad++;
        end
        vectors++;
        if (first != 11 || last != 74 || hi != 64) begin
            miscompares++;
            $display("FAIL single_window got first=%0d last=%0d high=%0d want 11 74 64", first, last, hi);
        end
        vectors++;
        if (any_bad != 0) begin
            miscompares++;
            $display("FAIL single_any got bad_cycles=%0d want 0", any_bad);
        end
    endtask

    task automatic test_coalesce();
        int pf = -1, pl = -1, cf = -1, rises = 0;
        logic prev = 1'b0;
        for (int r = 0; r < 160; r++) begin
            in_a[1] = (r >= 10 && r < 15) || (r >= 30 && r < 35) || (r >= 50 && r < 55);
            tick();
            e = sb.pop_front(); vectors++;
            if ({obs_a, obs_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("FAIL coal_sb r=%0d got a=%h b=%h want a=%h b=%h", r, obs_a, obs_b, e.a, e.b);
            end
            if (pend_a[1]) begin
                if (pf < 0) pf = r + 1;
                pl = r + 1;
            end
            if (coal_a[1] && cf < 0) cf = r + 1;
            if (!prev && out_a[1]) rises++;
            prev = out_a[1];
        end
        vectors++;
        if (pf != 31 || pl != 82 || cf != 51 || rises != 2) begin
            miscompares++;
            $display("FAIL coal_window got pend=%0d..%0d coal=%0d rises=%0d want 31..82 51 2", pf, pl, cf, rises);
        end
        vectors++;
        if (coal_a[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL coal_sticky got %b want 1", coal_a[1]);
        end
        clr_a[1] = 1'b1;
        tick();
        clr_a[1] = 1'b0;
        e = sb.pop_front(); vectors++;
        if (coal_a[1] !== 1'b0 || {obs_a, obs_b} !== {e.a, e.b}) begin
            miscompares++;
            $display("FAIL coal_clear got a=%h want a=%h coal 0", obs_a, e.a);
        end
    endtask

    task automatic test_level();
        int rises[8];
        int n = 0;
        logic prev = 1'b0;
        mode_a[2] = 1'b1;
        for (int r = 0; r < 440; r++) begin
            in_a[2] = (r < 300);
            tick();
            e = sb.pop_front(); vectors++;
            if ({obs_a, obs_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("FAIL level_sb r=%0d got a=%h b=%h want a=%h b=%h", r, obs_a, obs_b, e.a, e.b);
            end
            if (!prev && out_a[2] && r + 1 <= 300 && n < 8) begin
                rises[n] = r + 1;
                n++;
            end
            prev = out_a[2];
        end
        vectors++;
        if (n != 5) begin
            miscompares++;
            $display("FAIL level_count got %0d want 5", n);
        end
        for (int i = 0; i < 5 && i < n; i++) begin
            vectors++;
            if (rises[i] != 1 + 72 * i) begin
                miscompares++;
                $display("FAIL level_start i=%0d got %0d want %0d", i, rises[i], 1 + 72 * i);
            end
        end
        mode_a[2] = 1'b0;
        clr_a[2] = 1'b1;
        tick();
        clr_a[2] = 1'b0;
        e = sb.pop_front(); vectors++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin
            miscompares++;
            $display("FAIL level_clr got a=%h want a=%h", obs_a, e.a);
        end
    endtask

    task automatic test_mask_clear();
        int masked_bad = 0, rises = 0;
        logic prev = 1'b0;
        for (int r = 0; r < 180; r++) begin
            mask_a[3] = (r < 15);
            in_a[3]   = (r >= 5 && r < 10) || (r >= 20 && r < 25) || (r >= 40 && r < 45);
            clr_a[3]  = (r == 40) || (r == 60);
            tick();
            e = sb.pop_front(); vectors++;
            if ({obs_a, obs_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("FAIL mask_sb r=%0d got a=%h b=%h want a=%h b=%h", r, obs_a, obs_b, e.a, e.b);
            end
            if (r < 15 && (out_a[3] || pend_a[3])) masked_bad++;
            if (r == 40) begin
                vectors++;
                if (pend_a[3] !== 1'b1 || coal_a[3] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mask_ev_wins got pend=%b coal=%b want 1 0", pend_a[3], coal_a[3]);
                end
            end
            if (r == 60) begin
                vectors++;
                if (pend_a[3] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mask_clr got pend=%b want 0", pend_a[3]);
                end
            end
            if (!prev && out_a[3]) rises++;
            prev = out_a[3];
        end
        clr_a[3] = 1'b0;
        vectors++;
        if (masked_bad != 0 || rises != 1) begin
            miscompares++;
            $display("FAIL mask_result got masked_bad=%0d rises=%0d want 0 1", masked_bad, rises);
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 120; r++) begin
            in_a[0] = (r < 110);
            rst_a   = (r == 30);
            tick();
            e = sb.pop_front(); vectors++;
            if ({obs_a, obs_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("FAIL rstmid_sb r=%0d got a=%h b=%h want a=%h b=%h", r, obs_a, obs_b, e.a, e.b);
            end
            if (r == 30) begin
                vectors++;
                if (obs_a !== 13'h0) begin
                    miscompares++;
                    $display("FAIL rstmid_zero got %h want 0", obs_a);
                end
            end
            if (r == 31) begin
                vectors++;
                if (out_a[0] !== 1'b1 || any_a !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rstmid_refire got out=%b any=%b want 1 1", out_a[0], any_a);
                end
            end
        end
        rst_a = 1'b0;
    endtask

    task automatic test_boundary();
        int alt_bad = 0;
        rst_b = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            e = sb.pop_front(); vectors++;
            if ({obs_a, obs_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("FAIL bound_rst r=%0d got a=%h b=%h want a=%h b=%h", r, obs_a, obs_b, e.a, e.b);
            end
        end
        rst_b = 1'b0;
        for (int r = 0; r < 24; r++) begin
            in_b[0] = (r < 20) && (r % 2 == 0);
            tick();
            e = sb.pop_front(); vectors++;
            if ({obs_a, obs_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("FAIL bound_sb r=%0d got a=%h b=%h want a=%h b=%h", r, obs_a, obs_b, e.a, e.b);
            end
            if (r < 20 && out_b[0] !== (r % 2 == 0)) alt_bad++;
        end
        vectors++;
        if (alt_bad != 0) begin
            miscompares++;
            $display("FAIL bound_alt got bad_cycles=%0d want 0", alt_bad);
        end
        vectors++;
        if (pend_b !== '0 || coal_b !== '0 || out_b !== '0) begin
            miscompares++;
            $display("FAIL bound_end got pend=%b coal=%b out=%b want 0 0 0", pend_b, coal_b, out_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_coalesce();
        test_level();
        test_mask_clear();
        test_reset_mid();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
